// File: rtl/fetch_stage.sv
// Fetch stage: PC register, direct-mapped BTB with 2-bit counters, IF/ID register.
// Define FETCH_BHT_EN to build the BTB; without it fetch always predicts not-taken.
module fetch_stage #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  output logic [XLEN-1:0] PCF,
  input  logic [XLEN-1:0] InstrF,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            PredTakenD,
  output logic [XLEN-1:0] PredTargetD,
  input  logic            BranchE,
  input  logic            TakenE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [XLEN-1:0] PredTargetE,
  input  logic            PredTakenE,
  output logic            MispredictE
);

  localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
  localparam int unsigned TAGW = XLEN - IDX - 2;

  logic [XLEN-1:0] r_pcf;
  logic [XLEN-1:0] r_instr_d;
  logic [XLEN-1:0] r_pc_d;
  logic [XLEN-1:0] r_pcplus4_d;
  logic            r_pred_taken_d;
  logic [XLEN-1:0] r_pred_target_d;

  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_pcplus4_f;
  logic [XLEN-1:0] w_pcplus4_e;
  logic            w_pred_taken_f;
  logic [XLEN-1:0] w_pred_target_f;

  assign w_pcplus4_f = r_pcf + XLEN'(4);
  assign w_pcplus4_e = PCE + XLEN'(4);

`ifdef FETCH_BHT_EN
  logic            r_valid  [BTB_ENTRIES];
  logic [TAGW-1:0] r_tag    [BTB_ENTRIES];
  logic [XLEN-1:0] r_target [BTB_ENTRIES];
  logic [1:0]      r_cnt    [BTB_ENTRIES];

  logic [IDX-1:0]  w_idx_f;
  logic [IDX-1:0]  w_idx_e;
  logic            w_hit_f;
  logic            w_hit_e;

  assign w_idx_f = r_pcf[IDX+1:2];
  assign w_idx_e = PCE[IDX+1:2];
  assign w_hit_f = r_valid[w_idx_f] && (r_tag[w_idx_f] == r_pcf[XLEN-1:IDX+2]);
  assign w_hit_e = r_valid[w_idx_e] && (r_tag[w_idx_e] == PCE[XLEN-1:IDX+2]);

  assign w_pred_taken_f  = w_hit_f && r_cnt[w_idx_f][1];
  assign w_pred_target_f = w_pred_taken_f ? r_target[w_idx_f] : w_pcplus4_f;
  assign MispredictE     = BranchE &&
                           (PredTakenE ? (!TakenE || (PredTargetE != PCTargetE)) : TakenE);

  // Resolution training; lookup this cycle still sees the old entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= 2'b01;
      end
    end else if (BranchE) begin
      if (w_hit_e) begin
        if (TakenE) begin
          if (r_cnt[w_idx_e] != 2'b11) r_cnt[w_idx_e] <= r_cnt[w_idx_e] + 2'd1;
          r_target[w_idx_e] <= PCTargetE;
        end else if (r_cnt[w_idx_e] != 2'b00) begin
          r_cnt[w_idx_e] <= r_cnt[w_idx_e] - 2'd1;
        end
      end else if (TakenE) begin
        r_valid[w_idx_e]  <= 1'b1;
        r_tag[w_idx_e]    <= PCE[XLEN-1:IDX+2];
        r_target[w_idx_e] <= PCTargetE;
        r_cnt[w_idx_e]    <= 2'b10;
      end
    end
  end
`else
  logic w_unused;

  assign w_unused        = ^{PredTakenE, PredTargetE};
  assign w_pred_taken_f  = 1'b0;
  assign w_pred_target_f = w_pcplus4_f;
  assign MispredictE     = BranchE && TakenE;
`endif

  // Redirect beats stall beats prediction.
  always_comb begin
    w_pc_next = w_pred_target_f;
    if (MispredictE) begin
      w_pc_next = TakenE ? PCTargetE : w_pcplus4_e;
    end else if (StallF) begin
      w_pc_next = r_pcf;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pcf <= RESET_PC;
    else        r_pcf <= w_pc_next;
  end

  // IF/ID register: a mispredict clears it even while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr_d       <= '0;
      r_pc_d          <= '0;
      r_pcplus4_d     <= '0;
      r_pred_taken_d  <= 1'b0;
      r_pred_target_d <= '0;
    end else if (MispredictE || FlushD) begin
      r_instr_d       <= '0;
      r_pc_d          <= '0;
      r_pcplus4_d     <= '0;
      r_pred_taken_d  <= 1'b0;
      r_pred_target_d <= '0;
    end else if (!StallD) begin
      r_instr_d       <= InstrF;
      r_pc_d          <= r_pcf;
      r_pcplus4_d     <= w_pcplus4_f;
      r_pred_taken_d  <= w_pred_taken_f;
      r_pred_target_d <= w_pred_target_f;
    end
  end

  assign PCF         = r_pcf;
  assign InstrD      = r_instr_d;
  assign PCD         = r_pc_d;
  assign PCPlus4D    = r_pcplus4_d;
  assign PredTakenD  = r_pred_taken_d;
  assign PredTargetD = r_pred_target_d;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic against a BTB/PC model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h100;
`ifdef FETCH_BHT_EN
  localparam bit BHT = 1'b1;
`else
  localparam bit BHT = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        StallF, StallD, FlushD;
  logic [31:0] PCF, InstrF, InstrD, PCD, PCPlus4D, PredTargetD;
  logic        PredTakenD;
  logic        BranchE, TakenE, PredTakenE, MispredictE;
  logic [31:0] PCE, PCTargetE, PredTargetE;

  fetch_stage #(.XLEN(32), .BTB_ENTRIES(16), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCF(PCF), .InstrF(InstrF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .PredTakenD(PredTakenD), .PredTargetD(PredTargetD), .BranchE(BranchE),
    .TakenE(TakenE), .PCE(PCE), .PCTargetE(PCTargetE), .PredTargetE(PredTargetE),
    .PredTakenE(PredTakenE), .MispredictE(MispredictE)
  );

  always #5 clk = ~clk;

  int unsigned n_vec;
  int unsigned n_miss;

  // Reference model: architectural PC, IF/ID contents and a 16-slot BTB table.
  logic [31:0] m_pc, m_instr_d, m_pc_d, m_pc4_d, m_ptgt_d;
  bit          m_ptk_d;
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_cnt   [16];

  function automatic void model_reset();
    m_pc = RST_PC; m_instr_d = '0; m_pc_d = '0; m_pc4_d = '0; m_ptgt_d = '0; m_ptk_d = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_cnt[i] = 1;
    end
  endfunction

  function automatic int slot(input logic [31:0] pc);
    return int'(pc[5:2]);
  endfunction

  function automatic bit btb_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_tag[slot(pc)] == pc[31:6]);
  endfunction

  function automatic bit model_pred(input logic [31:0] pc);
    return BHT && btb_hit(pc) && (m_cnt[slot(pc)] >= 2);
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] pc);
    return model_pred(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
  endfunction

  function automatic bit model_mis();
    if (!BranchE) return 1'b0;
    if (!BHT) return TakenE;
    if (PredTakenE) return !TakenE || (PredTargetE != PCTargetE);
    return TakenE;
  endfunction

  function automatic void model_tick();
    bit          mis = model_mis();
    bit          ptk = model_pred(m_pc);
    logic [31:0] ptg = model_target(m_pc);
    int          s   = slot(PCE);
    bit          hit = btb_hit(PCE);
    logic [31:0] nxt;
    if (mis)         nxt = TakenE ? PCTargetE : PCE + 32'd4;
    else if (StallF) nxt = m_pc;
    else             nxt = ptg;
    if (mis || FlushD) begin
      m_instr_d = '0; m_pc_d = '0; m_pc4_d = '0; m_ptk_d = 1'b0; m_ptgt_d = '0;
    end else if (!StallD) begin
      m_instr_d = InstrF; m_pc_d = m_pc; m_pc4_d = m_pc + 32'd4; m_ptk_d = ptk; m_ptgt_d = ptg;
    end
    if (BHT && BranchE) begin
      if (hit) begin
        if (TakenE) begin
          m_cnt[s] = (m_cnt[s] + 1 > 3) ? 3 : m_cnt[s] + 1;
          m_tgt[s] = PCTargetE;
        end else begin
          m_cnt[s] = (m_cnt[s] - 1 < 0) ? 0 : m_cnt[s] - 1;
        end
      end else if (TakenE) begin
        m_valid[s] = 1'b1; m_tag[s] = PCE[31:6]; m_tgt[s] = PCTargetE; m_cnt[s] = 2;
      end
    end
    m_pc = nxt;
  endfunction

  task automatic tick();
    model_tick();
    @(posedge clk);
    @(negedge clk);
    InstrF = $urandom;
  endtask

  task automatic idle();
    BranchE = 1'b0; TakenE = 1'b0; PredTakenE = 1'b0; PCE = '0; PCTargetE = '0;
    PredTargetE = '0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
  endtask

  task automatic branch(input logic [31:0] pce, input logic tk, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptgt);
    BranchE = 1'b1; PCE = pce; TakenE = tk; PCTargetE = tgt; PredTakenE = ptk; PredTargetE = ptgt;
  endtask

  // Redirect fetch to pc through a taken branch living in slot 0.
  task automatic goto_pc(input logic [31:0] pc);
    branch(32'h1000, 1'b1, pc, 1'b0, 32'h0);
    tick();
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b0; idle(); InstrF = 32'h1234_5678;
    repeat (2) @(negedge clk);
    model_reset();
    n_vec++; if (PCF !== RST_PC) begin n_miss++; $display("FAIL rst_pcf got %h want %h", PCF, RST_PC); end
    n_vec++; if (InstrD !== 32'h0) begin n_miss++; $display("FAIL rst_instrd got %h want 0", InstrD); end
    n_vec++; if (PredTakenD !== 1'b0) begin n_miss++; $display("FAIL rst_ptk got %b want 0", PredTakenD); end
    reset = 1'b1;
    #1;
    n_vec++; if (InstrD !== 32'h0) begin n_miss++; $display("FAIL rel_instrd got %h want 0", InstrD); end
    n_vec++; if (MispredictE !== 1'b0) begin n_miss++; $display("FAIL rel_mis got %b want 0", MispredictE); end
    tick();
    n_vec++; if (PCF !== 32'h104) begin n_miss++; $display("FAIL seq_pc1 got %h want 104", PCF); end
    n_vec++; if (PCD !== 32'h100) begin n_miss++; $display("FAIL seq_pcd got %h want 100", PCD); end
    n_vec++; if (InstrD !== 32'h1234_5678) begin n_miss++; $display("FAIL seq_instrd got %h want 12345678", InstrD); end
    tick();
    n_vec++; if (PCF !== 32'h108) begin n_miss++; $display("FAIL seq_pc2 got %h want 108", PCF); end
    n_vec++; if (PCPlus4D !== 32'h108) begin n_miss++; $display("FAIL seq_pc4d got %h want 108", PCPlus4D); end
  endtask

  task automatic test_first_taken();
    branch(32'h20, 1'b1, 32'h40, 1'b0, 32'h0);
    #1;
    n_vec++; if (MispredictE !== 1'b1) begin n_miss++; $display("FAIL first_mis got %b want 1", MispredictE); end
    tick(); idle();
    n_vec++; if (PCF !== 32'h40) begin n_miss++; $display("FAIL first_pcf got %h want 40", PCF); end
    n_vec++; if (InstrD !== 32'h0 || PCD !== 32'h0) begin n_miss++; $display("FAIL first_flush got %h/%h want 0/0", InstrD, PCD); end
  endtask

  task automatic test_predict_hit();
    logic [31:0] exp_next;
    exp_next = BHT ? 32'h40 : 32'h24;
    goto_pc(32'h20);
    n_vec++; if (PCF !== 32'h20) begin n_miss++; $display("FAIL hit_goto got %h want 20", PCF); end
    tick();
    n_vec++; if (PCF !== exp_next) begin n_miss++; $display("FAIL hit_pcf got %h want %h", PCF, exp_next); end
    n_vec++; if (PredTakenD !== BHT) begin n_miss++; $display("FAIL hit_ptk got %b want %b", PredTakenD, BHT); end
    n_vec++; if (PredTargetD !== exp_next) begin n_miss++; $display("FAIL hit_ptgt got %h want %h", PredTargetD, exp_next); end
    branch(32'h20, 1'b1, 32'h40, BHT, 32'h40);
    #1;
    n_vec++; if (MispredictE !== !BHT) begin n_miss++; $display("FAIL hit_resolve got %b want %b", MispredictE, !BHT); end
    tick(); idle();
  endtask

  task automatic test_counter_down();
    for (int k = 0; k < 2; k++) begin
      branch(32'h20, 1'b0, 32'h40, 1'b1, 32'h40);
      #1;
      n_vec++; if (MispredictE !== BHT) begin n_miss++; $display("FAIL down_mis%0d got %b want %b", k, MispredictE, BHT); end
      tick(); idle();
      n_vec++; if (PCF !== (BHT ? 32'h24 : m_pc)) begin n_miss++; $display("FAIL down_pcf%0d got %h want %h", k, PCF, BHT ? 32'h24 : m_pc); end
    end
    goto_pc(32'h20);
    tick();
    n_vec++; if (PCF !== 32'h24) begin n_miss++; $display("FAIL down_third got %h want 24", PCF); end
    n_vec++; if (PredTakenD !== 1'b0) begin n_miss++; $display("FAIL down_ptk got %b want 0", PredTakenD); end
  endtask

  task automatic test_stall();
    logic [31:0] hold_pc, hold_i;
    hold_pc = m_pc; hold_i = m_instr_d;
    StallF = 1'b1; StallD = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++; if (PCF !== hold_pc) begin n_miss++; $display("FAIL stall_pcf%0d got %h want %h", k, PCF, hold_pc); end
      n_vec++; if (InstrD !== hold_i) begin n_miss++; $display("FAIL stall_instr%0d got %h want %h", k, InstrD, hold_i); end
    end
    branch(32'h80, 1'b1, 32'h200, 1'b0, 32'h0);
    #1;
    n_vec++; if (MispredictE !== 1'b1) begin n_miss++; $display("FAIL stall_mis got %b want 1", MispredictE); end
    tick();
    n_vec++; if (PCF !== 32'h200) begin n_miss++; $display("FAIL stall_redir got %h want 200", PCF); end
    n_vec++; if (InstrD !== 32'h0 || PCD !== 32'h0) begin n_miss++; $display("FAIL stall_clear got %h/%h want 0/0", InstrD, PCD); end
    idle();
  endtask

  task automatic test_alias();
    logic [31:0] exp60;
    exp60 = BHT ? 32'h300 : 32'h64;
    branch(32'h20, 1'b1, 32'h40, 1'b0, 32'h0); tick();
    branch(32'h60, 1'b1, 32'h300, 1'b0, 32'h0); tick(); idle();
    goto_pc(32'h20); tick();
    n_vec++; if (PCF !== 32'h24) begin n_miss++; $display("FAIL alias_evict got %h want 24", PCF); end
    n_vec++; if (PredTakenD !== 1'b0) begin n_miss++; $display("FAIL alias_ptk got %b want 0", PredTakenD); end
    goto_pc(32'h60); tick();
    n_vec++; if (PCF !== exp60) begin n_miss++; $display("FAIL alias_new got %h want %h", PCF, exp60); end
  endtask

  task automatic test_random();
    logic [31:0] pcs [6];
    logic [31:0] tgts [4];
    pcs  = '{32'h20, 32'h60, 32'hA0, 32'h40, 32'h24, 32'h1C};
    tgts = '{32'h20, 32'h60, 32'h40, 32'hA0};
    for (int c = 0; c < 500; c++) begin
      StallF      = ($urandom_range(3) == 0);
      StallD      = ($urandom_range(3) == 0);
      FlushD      = ($urandom_range(7) == 0);
      BranchE     = 1'($urandom_range(1));
      TakenE      = 1'($urandom_range(1));
      PredTakenE  = 1'($urandom_range(1));
      PCE         = pcs[$urandom_range(5)];
      PCTargetE   = tgts[$urandom_range(3)];
      PredTargetE = $urandom_range(1) ? PCTargetE : tgts[$urandom_range(3)];
      #1;
      n_vec++; if (MispredictE !== model_mis()) begin n_miss++; $display("FAIL rnd_mis c%0d got %b want %b", c, MispredictE, model_mis()); end
      n_vec++; if (PCF !== m_pc) begin n_miss++; $display("FAIL rnd_pcf c%0d got %h want %h", c, PCF, m_pc); end
      n_vec++; if (InstrD !== m_instr_d) begin n_miss++; $display("FAIL rnd_instr c%0d got %h want %h", c, InstrD, m_instr_d); end
      n_vec++; if (PCD !== m_pc_d || PCPlus4D !== m_pc4_d) begin n_miss++; $display("FAIL rnd_pcd c%0d got %h/%h want %h/%h", c, PCD, PCPlus4D, m_pc_d, m_pc4_d); end
      n_vec++; if (PredTakenD !== m_ptk_d || PredTargetD !== m_ptgt_d) begin n_miss++; $display("FAIL rnd_pred c%0d got %b/%h want %b/%h", c, PredTakenD, PredTargetD, m_ptk_d, m_ptgt_d); end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    branch(32'h20, 1'b1, 32'h40, 1'b0, 32'h0); tick();
    branch(32'h20, 1'b1, 32'h40, 1'b0, 32'h0); tick(); idle();
    #2 reset = 1'b0;
    #1;
    n_vec++; if (PCF !== RST_PC) begin n_miss++; $display("FAIL mid_pcf got %h want %h", PCF, RST_PC); end
    n_vec++; if (InstrD !== 32'h0 || PCD !== 32'h0 || PredTakenD !== 1'b0) begin n_miss++; $display("FAIL mid_ifid got %h/%h/%b want 0/0/0", InstrD, PCD, PredTakenD); end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    goto_pc(32'h20); tick();
    n_vec++; if (PCF !== 32'h24) begin n_miss++; $display("FAIL mid_btb got %h want 24", PCF); end
  endtask

  initial begin
    clk = 1'b0; n_vec = 0; n_miss = 0;
    test_reset();
    test_first_taken();
    test_predict_hit();
    test_counter_down();
    test_stall();
    test_alias();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
